// File: rtl/anti_theft_pkg.sv
// Shared types for the anti-theft controller: interval selection, time width, timer FSM states.
package anti_theft_pkg;

    localparam int TIME_W = 4;

    typedef enum logic [1:0] {
        SEL_ARM_DELAY,
        SEL_DRIVER_DELAY,
        SEL_PASSENGER_DELAY,
        SEL_ALARM_ON
    } interval_sel_t;

    typedef enum logic {
        IDLE,
        COUNT
    } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts clk cycles while run is high and pulses tick on each wrap.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000,
    parameter int PRESC_W  = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] cnt;

    // A clear on the same edge as a wrap suppresses the tick, so a restart never sees a stale second.
    assign tick = run && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/alarm_interval_timer.sv
// Countdown timer for the anti-theft FSM: latches one of four 4-bit delays and pulses expired at zero.
// Optional TIMER_DEBUG_EN adds remaining_out and tick_out observation ports.
module alarm_interval_timer
    import anti_theft_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int PRESC_W  = $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_timer,
    input  logic [1:0]        interval_sel,
    input  logic [TIME_W-1:0] t_arm_delay,
    input  logic [TIME_W-1:0] t_driver_delay,
    input  logic [TIME_W-1:0] t_passenger_delay,
    input  logic [TIME_W-1:0] t_alarm_on,
    output logic              busy,
    output logic              expired
`ifdef TIMER_DEBUG_EN
    ,
    output logic [TIME_W-1:0] remaining_out,
    output logic              tick_out
`endif
);

    // start_timer is a single-cycle request with no ready: it is always accepted and
    // overrides any countdown in progress, including one that would expire on that edge.

    timer_state_t      state;
    logic [TIME_W-1:0] remaining;
    logic [TIME_W-1:0] sel_value;
    logic              tick;

    always_comb begin
        sel_value = t_arm_delay;
        case (interval_sel_t'(interval_sel))
            SEL_ARM_DELAY:       sel_value = t_arm_delay;
            SEL_DRIVER_DELAY:    sel_value = t_driver_delay;
            SEL_PASSENGER_DELAY: sel_value = t_passenger_delay;
            SEL_ALARM_ON:        sel_value = t_alarm_on;
            default:             sel_value = t_arm_delay;
        endcase
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV),
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(start_timer),
        .run  (state == COUNT),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else if (start_timer) begin
            state     <= COUNT;
            remaining <= sel_value;
            busy      <= 1'b1;
            expired   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy    <= 1'b0;
                    expired <= 1'b0;
                end
                COUNT: begin
                    expired <= 1'b0;
                    // A zero interval completes on the first edge instead of wrapping to 15.
                    if (remaining == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        expired <= 1'b1;
                    end else if (tick) begin
                        remaining <= remaining - TIME_W'(1);
                        if (remaining == TIME_W'(1)) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            expired <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIMER_DEBUG_EN
    assign remaining_out = remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_out <= 1'b0;
        end else begin
            tick_out <= tick;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Bench for alarm_interval_timer: directed plan plus random starts/reprogramming against a deadline model.
// Build with TIMER_DEBUG_EN to also check remaining_out and tick_out.
module tb_alarm_interval_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_timer = 1'b0;
    logic [1:0] interval_sel = 2'd0;
    logic [3:0] t_arm_delay = 4'd0;
    logic [3:0] t_driver_delay = 4'd0;
    logic [3:0] t_passenger_delay = 4'd0;
    logic [3:0] t_alarm_on = 4'd0;
    logic       busy;
    logic       expired;
`ifdef TIMER_DEBUG_EN
    logic [3:0] remaining_out;
    logic       tick_out;
`endif

    alarm_interval_timer #(.TICK_DIV(TD)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_timer      (start_timer),
        .interval_sel     (interval_sel),
        .t_arm_delay      (t_arm_delay),
        .t_driver_delay   (t_driver_delay),
        .t_passenger_delay(t_passenger_delay),
        .t_alarm_on       (t_alarm_on),
        .busy             (busy),
        .expired          (expired)
`ifdef TIMER_DEBUG_EN
        ,
        .remaining_out    (remaining_out),
        .tick_out         (tick_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Reference model: absolute cycle of the pending expiry (-1 = none).
    int deadline = -1;
    int start_cyc = 0;
    bit zero_v = 1'b0;

    // {remaining[3:0], tick, busy, expired}
    logic [6:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input logic [1:0] sel);
        case (sel)
            2'd0: pick = t_arm_delay;
            2'd1: pick = t_driver_delay;
            2'd2: pick = t_passenger_delay;
            default: pick = t_alarm_on;
        endcase
    endfunction

    task automatic model_edge(input logic st, input logic [3:0] v);
        logic       e_exp;
        logic       e_tick;
        logic       e_busy;
        logic [3:0] e_rem;
        e_tick = !st && deadline >= n && !zero_v && n > start_cyc && ((n - start_cyc) % TD == 0);
        if (st) begin
            deadline  = n + ((v == 0) ? 1 : int'(v) * TD);
            start_cyc = n;
            zero_v    = (v == 0);
            e_exp     = 1'b0;
        end else begin
            e_exp = (deadline == n);
            if (e_exp) deadline = -1;
        end
        e_busy = (deadline != -1);
        if (deadline == -1 || zero_v) e_rem = 4'd0;
        else e_rem = 4'((deadline - n + TD - 1) / TD);
        exp_q.push_back({e_rem, e_tick, e_busy, e_exp});
    endtask

    task automatic compare_outputs();
        logic [6:0] e;
        e = exp_q.pop_front();
        check_eq("busy", {7'd0, busy}, {7'd0, e[1]});
        check_eq("expired", {7'd0, expired}, {7'd0, e[0]});
`ifdef TIMER_DEBUG_EN
        check_eq("tick_out", {7'd0, tick_out}, {7'd0, e[2]});
        check_eq("remaining_out", {4'd0, remaining_out}, {4'd0, e[6:3]});
`endif
    endtask

    task automatic cycle(input logic st, input logic [1:0] sel);
        logic [3:0] v;
        @(negedge clk);
        start_timer  = st;
        interval_sel = sel;
        v = pick(sel);
        @(posedge clk);
        n++;
        #1;
        model_edge(st, v);
        compare_outputs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 2'd0);
    endtask

    initial begin
        // Reset held for 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_busy", {7'd0, busy}, 8'd0);
        check_eq("reset_expired", {7'd0, expired}, 8'd0);
`ifdef TIMER_DEBUG_EN
        check_eq("reset_remaining", {4'd0, remaining_out}, 8'd0);
`endif

        // Basic count: 6 seconds
        t_arm_delay = 4'd6;
        cycle(1'b1, 2'd0);
        idle(27);

        // Zero interval, then maximum interval
        t_alarm_on = 4'd0;
        cycle(1'b1, 2'd3);
        idle(3);
        t_passenger_delay = 4'd15;
        cycle(1'b1, 2'd2);
        idle(64);

        // Restart at cycle 10 of an 8-second count
        t_driver_delay = 4'd8;
        cycle(1'b1, 2'd1);
        idle(9);
        cycle(1'b1, 2'd0);
        idle(28);

        // Reprogramming during a count has no effect
        cycle(1'b1, 2'd1);
        idle(2);
        t_driver_delay = 4'd2;
        idle(33);

        // Start on the same edge as the final tick, then start while expired is high
        t_arm_delay = 4'd1;
        cycle(1'b1, 2'd0);
        idle(3);
        t_driver_delay = 4'd2;
        cycle(1'b1, 2'd1);
        idle(8);
        cycle(1'b1, 2'd0);
        idle(6);

        // Asynchronous reset mid-count
        t_arm_delay = 4'd6;
        cycle(1'b1, 2'd0);
        idle(12);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", {7'd0, busy}, 8'd0);
        check_eq("async_rst_expired", {7'd0, expired}, 8'd0);
        deadline = -1;
        zero_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        t_arm_delay = 4'd1;
        cycle(1'b1, 2'd0);
        idle(6);

        // Random starts, selections and reprogramming
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: t_arm_delay = 4'($urandom_range(0, 4));
                    1: t_driver_delay = 4'($urandom_range(0, 4));
                    2: t_passenger_delay = 4'($urandom_range(0, 15));
                    default: t_alarm_on = 4'($urandom_range(0, 3));
                endcase
            end
            cycle(($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
